// File: rtl/pe_dot_accum_tree_if.sv
// Beat/result bundle between the PE multiplier array, the dot accumulator and the drain logic.
interface pe_dot_accum_tree_if #(
    parameter int MULT_OUTPUT_WIDTH = 16,
    parameter int DOT_SIZE          = 8,
    parameter int ACCUM_WIDTH       = 40
);
    logic                                        i_valid;
    logic                                        i_first;
    logic                                        i_last;
    logic [DOT_SIZE-1:0][MULT_OUTPUT_WIDTH-1:0]  i_mult_output;
    logic                                        o_valid;
    logic [ACCUM_WIDTH-1:0]                      o_result;
    logic                                        o_overflow;
    logic                                        o_abort;

    modport master (
        output i_valid, i_first, i_last, i_mult_output,
        input  o_valid, o_result, o_overflow, o_abort
    );

    modport slave (
        input  i_valid, i_first, i_last, i_mult_output,
        output o_valid, o_result, o_overflow, o_abort
    );
endinterface

// File: rtl/pe_dot_accum_tree.sv
// Pipelined dot-product adder tree feeding a framed group accumulator.
// Define PE_DOT_ACCUM_SAT_EN to saturate the accumulator instead of wrapping.
module pe_dot_accum_tree #(
    parameter int MULT_OUTPUT_WIDTH = 16,
    parameter int DOT_SIZE          = 8,
    parameter int ACCUM_WIDTH       = 40,
    parameter int REG_EVERY         = 1,
    parameter bit INPUT_SIGN_MAG    = 1'b1
) (
    input logic                clock,
    input logic                reset,
    pe_dot_accum_tree_if.slave bus
);
    localparam int LEVELS = $clog2(DOT_SIZE);
    localparam int CW     = MULT_OUTPUT_WIDTH + 1;
    localparam int SW     = CW + LEVELS;
    localparam int MSB    = ACCUM_WIDTH - 1;

    localparam logic signed [ACCUM_WIDTH-1:0] AccMax = {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
    localparam logic signed [ACCUM_WIDTH-1:0] AccMin = {1'b1, {(ACCUM_WIDTH-1){1'b0}}};

    // Stage 0: convert every lane to two's complement; ctl is {valid, first, last}
    logic signed [CW-1:0] conv_d [DOT_SIZE];
    logic signed [CW-1:0] conv_q [DOT_SIZE];
    logic [2:0]           ctl0_d, ctl0_q;

    always_comb begin
        for (int i = 0; i < DOT_SIZE; i++) begin
            if (INPUT_SIGN_MAG) begin
                conv_d[i] = {2'b00, bus.i_mult_output[i][MULT_OUTPUT_WIDTH-2:0]};
                if (bus.i_mult_output[i][MULT_OUTPUT_WIDTH-1]) conv_d[i] = -conv_d[i];
            end else begin
                conv_d[i] = {bus.i_mult_output[i][MULT_OUTPUT_WIDTH-1], bus.i_mult_output[i]};
            end
        end
        ctl0_d = bus.i_valid ? {1'b1, bus.i_first, bus.i_last} : 3'b000;
    end

    always_ff @(posedge clock) begin
        conv_q <= conv_d;
        if (reset) ctl0_q <= '0;
        else       ctl0_q <= ctl0_d;
    end

    // Tree: level l holds DOT_SIZE>>l partial sums, registered every REG_EVERY levels and at the root
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N = DOT_SIZE >> l;
        logic signed [SW-1:0] val [N];
        logic [2:0]           ctl;

        if (l == 0) begin : g_in
            for (genvar i = 0; i < N; i++) begin : g_ext
                assign val[i] = SW'(conv_q[i]);
            end
            assign ctl = ctl0_q;
        end else begin : g_add
            logic signed [SW-1:0] sum_d [N];

            always_comb begin
                for (int i = 0; i < N; i++) begin
                    sum_d[i] = g_lvl[l-1].val[2*i] + g_lvl[l-1].val[2*i+1];
                end
            end

            if ((l % REG_EVERY == 0) || (l == LEVELS)) begin : g_reg
                logic signed [SW-1:0] sum_q [N];
                logic [2:0]           ctl_q;
                always_ff @(posedge clock) begin
                    sum_q <= sum_d;
                    if (reset) ctl_q <= '0;
                    else       ctl_q <= g_lvl[l-1].ctl;
                end
                assign val = sum_q;
                assign ctl = ctl_q;
            end else begin : g_comb
                assign val = sum_d;
                assign ctl = g_lvl[l-1].ctl;
            end
        end
    end

    // Accumulator stage
    typedef enum logic {StIdle, StAccum} state_e;

    state_e                         state_d, state_q;
    logic signed [ACCUM_WIDTH-1:0]  sum_ext, add, add_sat, acc_new;
    logic signed [ACCUM_WIDTH-1:0]  acc_d, acc_q, result_d, result_q;
    logic                           ovf_d, ovf_q, oovf_d, oovf_q, ovf_new;
    logic                           valid_d, valid_q, abort_d, abort_q;
    logic                           add_ovf, tree_v, tree_f, tree_l;

    assign {tree_v, tree_f, tree_l} = g_lvl[LEVELS].ctl;
    assign sum_ext = ACCUM_WIDTH'(g_lvl[LEVELS].val[0]);
    assign add     = acc_q + sum_ext;
    assign add_ovf = (acc_q[MSB] == sum_ext[MSB]) && (add[MSB] != acc_q[MSB]);

`ifdef PE_DOT_ACCUM_SAT_EN
    assign add_sat = add_ovf ? (sum_ext[MSB] ? AccMin : AccMax) : add;
`else
    assign add_sat = add;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        abort_d  = 1'b0;
        result_d = result_q;
        oovf_d   = oovf_q;
        acc_new  = acc_q;
        ovf_new  = ovf_q;
        if (tree_v) begin
            // A first beat (or any beat while idle) restarts the sum; while open it aborts
            if (state_q == StIdle || tree_f) begin
                acc_new = sum_ext;
                ovf_new = 1'b0;
                abort_d = (state_q == StAccum);
            end else begin
                acc_new = add_sat;
                ovf_new = ovf_q | add_ovf;
            end
            if (tree_l) begin
                valid_d  = 1'b1;
                result_d = acc_new;
                oovf_d   = ovf_new;
                acc_d    = '0;
                ovf_d    = 1'b0;
                state_d  = StIdle;
            end else begin
                acc_d   = acc_new;
                ovf_d   = ovf_new;
                state_d = StAccum;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            abort_q  <= 1'b0;
            result_q <= '0;
            oovf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            abort_q  <= abort_d;
            result_q <= result_d;
            oovf_q   <= oovf_d;
        end
    end

    assign bus.o_valid    = valid_q;
    assign bus.o_result   = result_q;
    assign bus.o_overflow = oovf_q;
    assign bus.o_abort    = abort_q;
endmodule

// File: tb/tb_pe_dot_accum_tree.sv
// Five configurations of pe_dot_accum_tree share one stimulus stream and are checked
// cycle by cycle against a group-level arithmetic model.
module tb_pe_dot_accum_tree;
    localparam int NI   = 5;
    localparam int MW   = 16;
    localparam int DS   = 8;
    localparam int MAXC = 4096;

    function automatic int aw_of(int i);
        return (i == 2) ? 20 : 40;
    endfunction
    function automatic int re_of(int i);
        return (i == 3) ? 2 : (i == 4) ? 3 : 1;
    endfunction
    function automatic bit sm_of(int i);
        return i != 1;
    endfunction
    function automatic int lat_of(int i);
        int lv = $clog2(DS);
        return 2 + (lv + re_of(i) - 1) / re_of(i);
    endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                    in_v, in_f, in_l;
    logic [DS-1:0][MW-1:0]   in_d;
    logic                    dut_v [NI];
    logic                    dut_a [NI];
    logic                    dut_o [NI];
    longint                  dut_r [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pe_dot_accum_tree_if #(
            .MULT_OUTPUT_WIDTH (MW),
            .DOT_SIZE          (DS),
            .ACCUM_WIDTH       (aw_of(g))
        ) bus ();
        assign bus.i_valid       = in_v;
        assign bus.i_first       = in_f;
        assign bus.i_last        = in_l;
        assign bus.i_mult_output = in_d;
        pe_dot_accum_tree #(
            .MULT_OUTPUT_WIDTH (MW),
            .DOT_SIZE          (DS),
            .ACCUM_WIDTH       (aw_of(g)),
            .REG_EVERY         (re_of(g)),
            .INPUT_SIGN_MAG    (sm_of(g))
        ) u_dut (
            .clock (clk),
            .reset (rst),
            .bus   (bus)
        );
        assign dut_v[g] = bus.o_valid;
        assign dut_a[g] = bus.o_abort;
        assign dut_o[g] = bus.o_overflow;
        assign dut_r[g] = longint'($signed(bus.o_result));
    end

    // Beat history indexed by the clock edge that sampled it
    bit     hv [MAXC];
    bit     hf [MAXC];
    bit     hl [MAXC];
    longint hs_sm [MAXC];
    longint hs_tc [MAXC];
    int     cyc;
    int     last_rst;

    bit     open_m [NI];
    bit     ovf_m  [NI];
    bit     ovfh_m [NI];
    bit     v_m    [NI];
    bit     a_m    [NI];
    longint acc_m  [NI];
    longint res_m  [NI];

    int     vcnt [NI];
    int     acnt [NI];
    int     vcyc [NI];
    longint got_res [NI];
    bit     got_ovf [NI];

    int total;
    int bad;

    task automatic check(string tag, longint got, longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint lane_val(logic [15:0] x, bit sm);
        if (sm) return x[15] ? -longint'(x[14:0]) : longint'(x[14:0]);
        return longint'($signed(x));
    endfunction

    function automatic longint wrap(longint t, int w);
        longint m = 64'sd1 <<< w;
        longint r = t & (m - 1);
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    function automatic void model_edge(int i, int e);
        longint lo = -(64'sd1 <<< (aw_of(i) - 1));
        longint hi = -lo - 1;
        longint s, t;
        int     k = e - (lat_of(i) - 1);
        v_m[i] = 1'b0;
        a_m[i] = 1'b0;
        if (rst) begin
            open_m[i] = 1'b0;
            acc_m[i]  = 0;
            ovf_m[i]  = 1'b0;
            res_m[i]  = 0;
            ovfh_m[i] = 1'b0;
            return;
        end
        if (k < 0 || k <= last_rst || !hv[k]) return;
        s = sm_of(i) ? hs_sm[k] : hs_tc[k];
        if (!open_m[i] || hf[k]) begin
            a_m[i]   = open_m[i];
            acc_m[i] = s;
            ovf_m[i] = 1'b0;
        end else begin
            t = acc_m[i] + s;
            if (t > hi || t < lo) begin
                ovf_m[i] = 1'b1;
`ifdef PE_DOT_ACCUM_SAT_EN
                acc_m[i] = (t > hi) ? hi : lo;
`else
                acc_m[i] = wrap(t, aw_of(i));
`endif
            end else begin
                acc_m[i] = t;
            end
        end
        if (hl[k]) begin
            v_m[i]    = 1'b1;
            res_m[i]  = acc_m[i];
            ovfh_m[i] = ovf_m[i];
            open_m[i] = 1'b0;
        end else begin
            open_m[i] = 1'b1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
            $fatal(1);
        end
        hv[cyc]    = in_v;
        hf[cyc]    = in_f;
        hl[cyc]    = in_l;
        hs_sm[cyc] = 0;
        hs_tc[cyc] = 0;
        for (int j = 0; j < DS; j++) begin
            hs_sm[cyc] += lane_val(in_d[j], 1'b1);
            hs_tc[cyc] += lane_val(in_d[j], 1'b0);
        end
        if (rst) last_rst = cyc;
        for (int i = 0; i < NI; i++) model_edge(i, cyc);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("i%0d_valid", i), longint'(dut_v[i]), longint'(v_m[i]));
            check($sformatf("i%0d_abort", i), longint'(dut_a[i]), longint'(a_m[i]));
            check($sformatf("i%0d_result", i), dut_r[i], res_m[i]);
            if (v_m[i]) check($sformatf("i%0d_ovf", i), longint'(dut_o[i]), longint'(ovfh_m[i]));
            if (dut_v[i]) begin
                vcnt[i]++;
                vcyc[i]    = cyc;
                got_res[i] = dut_r[i];
                got_ovf[i] = dut_o[i];
            end
            if (dut_a[i]) acnt[i]++;
        end
        cyc++;
    endtask

    task automatic idle(int n);
        in_v = 1'b0;
        in_f = 1'b0;
        in_l = 1'b0;
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic beat(bit f, bit l, logic [15:0] x);
        in_v = 1'b1;
        in_f = f;
        in_l = l;
        in_d = {DS{x}};
        step();
        in_v = 1'b0;
        in_f = 1'b0;
        in_l = 1'b0;
    endtask

    int c0;
    int vc0;
    int ac0;

    initial begin
        total    = 0;
        bad      = 0;
        cyc      = 0;
        last_rst = -1;
        in_d     = '0;
        rst      = 1'b1;
        idle(2);
        rst = 1'b0;
        check("reset_result", dut_r[0], 0);
        check("reset_ovf", longint'(dut_o[0]), 0);

        // Single beat of ones; also measures per-configuration latency
        c0 = cyc;
        beat(1'b1, 1'b1, 16'h0001);
        idle(6);
        check("one_result", got_res[0], 8);
        check("one_ovf", longint'(got_ovf[0]), 0);
        for (int i = 0; i < NI; i++) check($sformatf("i%0d_latency", i), vcyc[i] - c0 + 1, lat_of(i));

        beat(1'b1, 1'b1, 16'h8003);
        idle(6);
        check("sm_neg3", got_res[0], -24);
        beat(1'b1, 1'b1, 16'h8000);
        idle(6);
        check("sm_negzero", got_res[0], 0);
        beat(1'b1, 1'b1, 16'hFFFD);
        idle(6);
        check("tc_neg3", got_res[1], -24);

        // Four-beat group with a gap
        beat(1'b1, 1'b0, 16'h0001);
        beat(1'b0, 1'b0, 16'h0001);
        idle(1);
        beat(1'b0, 1'b0, 16'h0001);
        beat(1'b0, 1'b1, 16'h0001);
        idle(6);
        check("gap_group", got_res[0], 32);

        vc0 = vcnt[0];
        for (int j = 0; j < 6; j++) beat(1'b1, 1'b1, 16'h0001);
        idle(6);
        check("b2b_count", vcnt[0] - vc0, 6);
        check("b2b_result", got_res[0], 8);

        beat(1'b1, 1'b0, 16'h7FFF);
        beat(1'b0, 1'b0, 16'h7FFF);
        beat(1'b0, 1'b1, 16'h7FFF);
        idle(6);
        check("ovf_flag", longint'(got_ovf[2]), 1);
`ifdef PE_DOT_ACCUM_SAT_EN
        check("ovf_result", got_res[2], 524287);
`else
        check("ovf_result", got_res[2], -262168);
`endif

        ac0 = acnt[0];
        beat(1'b1, 1'b0, 16'h0001);
        beat(1'b1, 1'b1, 16'h0002);
        idle(6);
        check("abort_count", acnt[0] - ac0, 1);
        check("abort_result", got_res[0], 16);

        // Reset while a three-beat group is in flight
        beat(1'b1, 1'b0, 16'h0001);
        beat(1'b0, 1'b0, 16'h0001);
        beat(1'b0, 1'b1, 16'h0001);
        vc0 = vcnt[0];
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_result", dut_r[0], 0);
        check("rst_mid_valid", longint'(dut_v[0]), 0);
        idle(6);
        check("rst_mid_dropped", vcnt[0] - vc0, 0);
        c0 = cyc;
        beat(1'b1, 1'b1, 16'h0001);
        idle(6);
        check("post_rst_result", got_res[0], 8);
        for (int i = 0; i < NI; i++) check($sformatf("i%0d_post_rst_lat", i), vcyc[i] - c0 + 1, lat_of(i));

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rst  = ($urandom_range(99) == 0);
            in_v = ($urandom_range(9) < 7);
            in_f = ($urandom_range(4) == 0);
            in_l = ($urandom_range(3) == 0);
            for (int j = 0; j < DS; j++) begin
                case ($urandom_range(3))
                    0:       in_d[j] = 16'($urandom);
                    1:       in_d[j] = 16'h7FFF;
                    2:       in_d[j] = 16'h8000 | 16'($urandom_range(15));
                    default: in_d[j] = 16'($urandom_range(255));
                endcase
            end
            step();
        end
        rst = 1'b0;
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
